// File: rtl/wave_sched_pkg.sv
// Shared types and defaults for the enemy-wave scheduler and per-frame helpers.
package wave_sched_pkg;

    localparam int unsigned SPEED_W = 24;
    localparam int unsigned SCAN_W  = 10;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned SCAN_H_MAX = 743;
    localparam int unsigned SCAN_V_MAX = 520;

    localparam int unsigned DEF_N_WAVES    = 3;
    localparam int unsigned DEF_GAP_FRAMES = 120;
    localparam int unsigned DEF_ACK_FRAMES = 2;

    localparam logic [SPEED_W-1:0] DEF_SPEED_INIT = 24'd948575;
    localparam logic [SPEED_W-1:0] DEF_SPEED_STEP = 24'd65536;
    localparam logic [SPEED_W-1:0] DEF_SPEED_MIN  = 24'd262144;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GAP     = 3'd1,
        LAUNCH  = 3'd2,
        ACK     = 3'd3,
        RUN     = 3'd4,
        ADVANCE = 3'd5
    } sched_state_t;

    // One step faster per round; compared in SPEED_W+1 bits so floor+step cannot wrap.
    function automatic logic [SPEED_W-1:0] speed_after_round(
        input logic [SPEED_W-1:0] cur,
        input logic [SPEED_W-1:0] step,
        input logic [SPEED_W-1:0] floor_val
    );
        logic [SPEED_W:0] thresh;
        logic [SPEED_W-1:0] result;
        thresh = {1'b0, floor_val} + {1'b0, step};
        if ({1'b0, cur} < thresh) begin
            result = floor_val;
        end else begin
            result = cur - step;
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle pulse, registered, in the cycle after the last pixel of each frame.
module frame_tick_gen
    import wave_sched_pkg::*;
#(
    parameter int unsigned H_MAX = SCAN_H_MAX,
    parameter int unsigned V_MAX = SCAN_V_MAX
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic [SCAN_W-1:0] x,
    input  logic [SCAN_W-1:0] y,
    output logic              frame_tick
);

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (x == SCAN_W'(H_MAX)) && (y == SCAN_W'(V_MAX));
        end
    end

endmodule

// File: rtl/wave_scheduler.sv
// Round-robin launcher for enemy waves: gap frames, launch pulse, clearance tracking
// and per-round speed-up of the shared wave period.
module wave_scheduler
    import wave_sched_pkg::*;
#(
    parameter int unsigned        N_WAVES    = DEF_N_WAVES,
    parameter int unsigned        GAP_FRAMES = DEF_GAP_FRAMES,
    parameter int unsigned        ACK_FRAMES = DEF_ACK_FRAMES,
    parameter logic [SPEED_W-1:0] SPEED_INIT = DEF_SPEED_INIT,
    parameter logic [SPEED_W-1:0] SPEED_STEP = DEF_SPEED_STEP,
    parameter logic [SPEED_W-1:0] SPEED_MIN  = DEF_SPEED_MIN,
    parameter int unsigned        H_MAX      = SCAN_H_MAX,
    parameter int unsigned        V_MAX      = SCAN_V_MAX
) (
    input  logic                dclk,
    input  logic                rst,
    input  logic                pause,
    input  logic                game_start_on,
    input  logic                game_over_on,
    input  logic [SCAN_W-1:0]   x,
    input  logic [SCAN_W-1:0]   y,
    input  logic [N_WAVES-1:0]  wave_active,
    output logic [N_WAVES-1:0]  wave_launch,
    output logic [SPEED_W-1:0]  wave_speed,
    output logic [IDX_W-1:0]    wave_idx,
    output logic [ROUND_W-1:0]  round_cnt,
    output logic                sched_busy
);

    sched_state_t         state_q, state_d;
    logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]     ack_cnt_q, ack_cnt_d;
    logic [N_WAVES-1:0]   launch_d;
    logic [SPEED_W-1:0]   speed_d;
    logic [IDX_W-1:0]     idx_d;
    logic [ROUND_W-1:0]   round_d;
    logic                 busy_d;

    logic                 frame_tick;
    logic [N_WAVES-1:0]   cur_onehot;
    logic                 cur_active;
    logic                 last_wave;

    frame_tick_gen #(
        .H_MAX (H_MAX),
        .V_MAX (V_MAX)
    ) u_frame_tick (
        .dclk       (dclk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick)
    );

    // Mask-based select avoids an index wider than the wave vector needs.
    assign cur_onehot = N_WAVES'(1) << wave_idx;
    assign cur_active = |(wave_active & cur_onehot);
    assign last_wave  = (wave_idx == IDX_W'(N_WAVES - 1));

    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_cnt_q   <= '0;
            ack_cnt_q   <= '0;
            wave_launch <= '0;
            wave_speed  <= SPEED_INIT;
            wave_idx    <= '0;
            round_cnt   <= '0;
            sched_busy  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            wave_launch <= launch_d;
            wave_speed  <= speed_d;
            wave_idx    <= idx_d;
            round_cnt   <= round_d;
            sched_busy  <= busy_d;
        end
    end

    // Launch is emitted on leaving LAUNCH, so a paused LAUNCH holds with no pulse
    // and wave_launch defaults low every cycle, keeping it a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        ack_cnt_d = ack_cnt_q;
        launch_d  = '0;
        speed_d   = wave_speed;
        idx_d     = wave_idx;
        round_d   = round_cnt;

        if (game_over_on) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
            ack_cnt_d = '0;
        end else if (game_start_on) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
            ack_cnt_d = '0;
            speed_d   = SPEED_INIT;
            idx_d     = '0;
            round_d   = '0;
        end else if (!pause) begin
            unique case (state_q)
                IDLE: begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
                GAP: begin
                    if (gap_cnt_q == CNT_W'(GAP_FRAMES)) begin
                        state_d = LAUNCH;
                    end else if (frame_tick) begin
                        gap_cnt_d = gap_cnt_q + CNT_W'(1);
                    end
                end
                LAUNCH: begin
                    launch_d  = cur_onehot;
                    state_d   = ACK;
                    ack_cnt_d = '0;
                end
                ACK: begin
                    if (cur_active) begin
                        state_d = RUN;
                    end else if (ack_cnt_q == CNT_W'(ACK_FRAMES)) begin
                        state_d = ADVANCE;
                    end else if (frame_tick) begin
                        ack_cnt_d = ack_cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!cur_active) begin
                        state_d = ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (last_wave) begin
                        idx_d   = '0;
                        speed_d = speed_after_round(wave_speed, SPEED_STEP, SPEED_MIN);
                        if (round_cnt != {ROUND_W{1'b1}}) begin
                            round_d = round_cnt + ROUND_W'(1);
                        end
                    end else begin
                        idx_d = wave_idx + IDX_W'(1);
                    end
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule
